// File: rtl/cr_xp10_decomp_be_ob_sched_pkg.sv
// Shared types for the XP10 decompressor back-end outbound scheduler.
// TLV bus struct, scheduler state enum and the default data-hdr typen.
package cr_xp10_decomp_be_ob_sched_pkg;

  typedef struct packed {
    logic [7:0]  typen;
    logic        sot;
    logic        eot;
    logic        tlast;
    logic [31:0] tdata;
  } tlvp_if_bus_t;

  typedef enum logic [1:0] {
    PT  = 2'd0,
    LZ  = 2'd1,
    ERR = 2'd2
  } be_ob_sched_state_e;

  localparam logic [7:0] BE_OB_DATA_TYPEN = 8'h0A;

  function automatic logic is_data_hdr(
    input tlvp_if_bus_t t,
    input logic [7:0]   typen
  );
    return t.sot & (t.typen == typen);
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_be_ob_reg.sv
// One-entry TLV register slice with valid/ready hold.
// o_can_load tells the producer when a new word may be written.
module cr_xp10_decomp_be_ob_reg
  import cr_xp10_decomp_be_ob_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  tlvp_if_bus_t i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output tlvp_if_bus_t o_data,
  output logic         o_can_load
);

  logic         r_valid;
  tlvp_if_bus_t r_data;
  logic         w_can_load;

  assign w_can_load = ~r_valid | i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load & w_can_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_can_load = w_can_load;

endmodule

// File: rtl/cr_xp10_decomp_be_ob_sched.sv
// XP10 decomp back-end outbound scheduler: passthrough vs LZ data onto one stream.
// Optional statistics counters: define CR_XP10_DECOMP_BE_OB_SCHED_STATS_EN.
module cr_xp10_decomp_be_ob_sched
  import cr_xp10_decomp_be_ob_sched_pkg::*;
#(
  parameter logic [7:0] DATA_TYPEN  = BE_OB_DATA_TYPEN,
  parameter int         STALL_LIMIT = 4096,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pt_empty,
  input  tlvp_if_bus_t     pt_tlv,
  output logic             pt_rd,
  input  logic             lz_empty,
  input  tlvp_if_bus_t     lz_tlv,
  output logic             lz_rd,
  output logic             ob_valid,
  output tlvp_if_bus_t     ob_tlv,
  input  logic             ob_ready,
  output logic [1:0]       sched_state,
  output logic             stall_err,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stat_frames,
  output logic [CNT_W-1:0] stat_words
);

  localparam logic [15:0] LIM = 16'(STALL_LIMIT);

  be_ob_sched_state_e r_state, w_nxt;
  logic [15:0]        r_stall, w_stall_nxt;
  logic               r_stall_err;
  logic               w_set_err;
  logic               w_can_load;
  logic               w_pt_rd, w_lz_rd;
  logic               w_ph, w_load;
  tlvp_if_bus_t       w_din;

  assign w_ph = is_data_hdr(pt_tlv, DATA_TYPEN);

  always_comb begin
    w_pt_rd   = 1'b0;
    w_lz_rd   = 1'b0;
    w_set_err = 1'b0;
    w_nxt     = PT;
    case (r_state)
      LZ, ERR: begin
        w_nxt   = r_state;
        w_lz_rd = ~rst & ~lz_empty & w_can_load;
        if (w_lz_rd & lz_tlv.eot) begin
          w_nxt = PT;
        end else if ((r_state == LZ) & lz_empty &
                     (r_stall >= LIM - 16'd1)) begin
          w_nxt     = ERR;
          w_set_err = 1'b1;
        end
      end
      default: begin
        w_pt_rd = ~rst & ~pt_empty & w_can_load;
        if (w_pt_rd & w_ph) w_nxt = LZ;
      end
    endcase
  end

  always_comb begin
    w_stall_nxt = r_stall;
    if (w_lz_rd | (w_nxt != r_state)) begin
      w_stall_nxt = '0;
    end else if ((r_state == LZ | r_state == ERR) &
                 lz_empty & (r_stall < LIM)) begin
      w_stall_nxt = r_stall + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PT;
      r_stall     <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_stall <= w_stall_nxt;
      if (w_set_err)      r_stall_err <= 1'b1;
      else if (stall_clr) r_stall_err <= 1'b0;
    end
  end

  assign w_load = w_lz_rd | (w_pt_rd & ~w_ph);
  assign w_din  = w_lz_rd ? lz_tlv : pt_tlv;

  cr_xp10_decomp_be_ob_reg u_ob_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_data     (w_din),
    .i_ready    (ob_ready),
    .o_valid    (ob_valid),
    .o_data     (ob_tlv),
    .o_can_load (w_can_load)
  );

  assign pt_rd       = w_pt_rd;
  assign lz_rd       = w_lz_rd;
  assign sched_state = r_state;
  assign stall_err   = r_stall_err;

`ifdef CR_XP10_DECOMP_BE_OB_SCHED_STATS_EN
  logic             r_tag;
  logic [CNT_W-1:0] r_frames, r_words;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag    <= 1'b0;
      r_frames <= '0;
      r_words  <= '0;
    end else begin
      if (w_load & w_can_load) r_tag <= w_lz_rd;
      if (ob_valid & ob_ready) begin
        r_words <= r_words + CNT_W'(1);
        if (r_tag & ob_tlv.eot) r_frames <= r_frames + CNT_W'(1);
      end
    end
  end

  assign stat_frames = r_frames;
  assign stat_words  = r_words;
`else
  assign stat_frames = '0;
  assign stat_words  = '0;
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_be_ob_sched.sv
// Directed bench for the XP10 back-end outbound scheduler.
// Models show-ahead FIFOs with queues and checks the outbound stream.
module tb_cr_xp10_decomp_be_ob_sched;
  import cr_xp10_decomp_be_ob_sched_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             pt_empty, lz_empty;
  tlvp_if_bus_t     pt_tlv, lz_tlv, ob_tlv;
  logic             pt_rd, lz_rd, ob_valid, ob_ready;
  logic [1:0]       sched_state;
  logic             stall_err, stall_clr;
  logic [CNT_W-1:0] stat_frames, stat_words;

  cr_xp10_decomp_be_ob_sched #(
    .DATA_TYPEN  (8'h0A),
    .STALL_LIMIT (16),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pt_empty    (pt_empty),
    .pt_tlv      (pt_tlv),
    .pt_rd       (pt_rd),
    .lz_empty    (lz_empty),
    .lz_tlv      (lz_tlv),
    .lz_rd       (lz_rd),
    .ob_valid    (ob_valid),
    .ob_tlv      (ob_tlv),
    .ob_ready    (ob_ready),
    .sched_state (sched_state),
    .stall_err   (stall_err),
    .stall_clr   (stall_clr),
    .stat_frames (stat_frames),
    .stat_words  (stat_words)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  tlvp_if_bus_t pt_q[$], lz_q[$], out_q[$];
  logic toggle = 1'b0;
  logic saw_lz;
  logic last_prd;
  int   lz_pops;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tlvp_if_bus_t mk(input logic [7:0] ty, input logic s,
                                      input logic e, input logic [31:0] d);
    tlvp_if_bus_t t;
    t.typen = ty; t.sot = s; t.eot = e; t.tlast = e; t.tdata = d;
    return t;
  endfunction

  // Called at a falling edge; advances one clock
  task automatic tick();
    logic prd, lrd, hold;
    tlvp_if_bus_t held;
    pt_empty = (pt_q.size() == 0);
    pt_tlv   = pt_empty ? '0 : pt_q[0];
    lz_empty = (lz_q.size() == 0);
    lz_tlv   = lz_empty ? '0 : lz_q[0];
    if (toggle) ob_ready = ~ob_ready;
    #1;
    prd  = pt_rd;
    lrd  = lz_rd;
    hold = ob_valid & ~ob_ready;
    held = ob_tlv;
    last_prd = prd;
    if (sched_state == 2'd1) saw_lz = 1'b1;
    if (hold) chk("pop_in_hold", {62'd0, prd, lrd}, 64'd0);
    if (prd & lrd) chk("both_rd", 64'd1, 64'd0);
    if (ob_valid & ob_ready) out_q.push_back(ob_tlv);
    if (prd) void'(pt_q.pop_front());
    if (lrd) begin void'(lz_q.pop_front()); lz_pops++; end
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      chk("hold_tlv", ob_tlv, held);
      chk("hold_valid", ob_valid, 1'b1);
    end
  endtask

  task automatic run_out(input int n, input int budget, input string tag);
    int b = 0;
    while (out_q.size() < n && b < budget) begin tick(); b++; end
    chk(tag, out_q.size(), n);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("rst_valid", ob_valid, 1'b0);
    chk("rst_state", sched_state, 2'd0);
    chk("rst_rd", {pt_rd, lz_rd}, 2'b00);
    pt_q.delete(); lz_q.delete(); out_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lz_pops = 0;
  endtask

  tlvp_if_bus_t p1, p2, ph, la, lb, s1, p5, l3, p7, p8, pa, p3, lzz;

  initial begin
    p1  = mk(8'h01, 1'b1, 1'b1, 32'h1111);
    p2  = mk(8'h02, 1'b1, 1'b1, 32'h2222);
    ph  = mk(8'h0A, 1'b1, 1'b1, 32'hDEAD);
    la  = mk(8'h0A, 1'b1, 1'b0, 32'hAAAA);
    lb  = mk(8'h0A, 1'b0, 1'b1, 32'hBBBB);
    s1  = mk(8'h0A, 1'b1, 1'b1, 32'h5151);
    p5  = mk(8'h05, 1'b1, 1'b1, 32'h5555);
    l3  = mk(8'h0A, 1'b0, 1'b0, 32'h3333);
    p7  = mk(8'h07, 1'b1, 1'b1, 32'h7777);
    p8  = mk(8'h08, 1'b1, 1'b1, 32'h8888);
    pa  = mk(8'h0A, 1'b0, 1'b1, 32'h0A0A);
    p3  = mk(8'h03, 1'b1, 1'b1, 32'h3030);
    lzz = mk(8'h0A, 1'b0, 1'b1, 32'hF00D);

    // Reset with a non-empty passthrough FIFO
    rst = 1'b1; stall_clr = 1'b0; ob_ready = 1'b1;
    pt_empty = 1'b0; pt_tlv = p1; lz_empty = 1'b0; lz_tlv = la;
    saw_lz = 1'b0; lz_pops = 0; last_prd = 1'b0;
    #1;
    chk("reset_valid", ob_valid, 1'b0);
    chk("reset_tlv", ob_tlv, 64'd0);
    chk("reset_state", sched_state, 2'd0);
    chk("reset_err", stall_err, 1'b0);
    chk("reset_rd", {pt_rd, lz_rd}, 2'b00);
    chk("reset_stats", {stat_frames, stat_words}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: PT 1,2, data header, LZ A,B(eot), ready high
    pt_q = '{p1, p2, ph};
    lz_q = '{la, lb};
    run_out(4, 30, "t1_count");
    chk("t1_w0", out_q[0], p1);
    chk("t1_w1", out_q[1], p2);
    chk("t1_w2", out_q[2], la);
    chk("t1_w3", out_q[3], lb);
    chk("t1_saw_lz", saw_lz, 1'b1);
    chk("t1_end_state", sched_state, 2'd0);
    chk("t1_idle", ob_valid, 1'b0);

    // 2: same stream with ready toggling every cycle
    out_q.delete();
    pt_q = '{p1, p2, ph};
    lz_q = '{la, lb};
    toggle = 1'b1;
    run_out(4, 40, "t2_count");
    toggle = 1'b0; ob_ready = 1'b1;
    chk("t2_w0", out_q[0], p1);
    chk("t2_w1", out_q[1], p2);
    chk("t2_w2", out_q[2], la);
    chk("t2_w3", out_q[3], lb);
    tick(); tick();
    chk("t2_end_state", sched_state, 2'd0);

    // 3: LZ stall with limit 16
    out_q.delete();
    pt_q = '{ph};
    begin
      int b = 0;
      while (sched_state != 2'd1 && b < 10) begin tick(); b++; end
    end
    chk("t3_in_lz", sched_state, 2'd1);
    repeat (15) tick();
    chk("t3_err_pre", stall_err, 1'b0);
    chk("t3_state_pre", sched_state, 2'd1);
    tick();
    chk("t3_err_set", stall_err, 1'b1);
    chk("t3_state_err", sched_state, 2'd2);
    lz_q = '{lb};
    tick();
    chk("t3_exit_state", sched_state, 2'd0);
    chk("t3_err_sticky", stall_err, 1'b1);
    tick();
    chk("t3_out", out_q[0], lb);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("t3_err_clr", stall_err, 1'b0);

    // 4: single-word LZ TLV then PT word 5
    pulse_rst();
    pt_q = '{ph, p5};
    lz_q = '{s1};
    run_out(2, 20, "t4_count");
    chk("t4_w0", out_q[0], s1);
    chk("t4_w1", out_q[1], p5);
    chk("t4_state", sched_state, 2'd0);
`ifdef CR_XP10_DECOMP_BE_OB_SCHED_STATS_EN
    chk("t4_frames", stat_frames, 1);
    chk("t4_words", stat_words, 2);
`else
    chk("t4_frames", stat_frames, 0);
    chk("t4_words", stat_words, 0);
`endif

    // 5: reset in the middle of an LZ frame
    pulse_rst();
    pt_q = '{ph};
    lz_q = '{la, l3, l3, lb};
    begin
      int b = 0;
      while (lz_pops < 3 && b < 20) begin tick(); b++; end
    end
    chk("t5_lz3", lz_pops, 3);
    chk("t5_in_lz", sched_state, 2'd1);
    pulse_rst();
    chk("t5_post_valid", ob_valid, 1'b0);
    chk("t5_post_state", sched_state, 2'd0);
    pt_q = '{p7, pa, p8};
    run_out(3, 20, "t5_count");
    chk("t5_w0", out_q[0], p7);
    chk("t5_w1", out_q[1], pa);
    chk("t5_w2", out_q[2], p8);
    chk("t5_state", sched_state, 2'd0);

    // 6: data header waits behind held output
    pulse_rst();
    ob_ready = 1'b0;
    pt_q = '{p3, ph};
    lz_q = '{lzz};
    tick();
    chk("t6_first_pop", last_prd, 1'b1);
    repeat (5) tick();
    chk("t6_ph_waiting", pt_q.size(), 1);
    chk("t6_no_lz_early", lz_pops, 0);
    chk("t6_held", ob_tlv, p3);
    ob_ready = 1'b1;
    tick();
    chk("t6_ph_pop", last_prd, 1'b1);
    chk("t6_ph_gone", pt_q.size(), 0);
    chk("t6_no_lz_same", lz_pops, 0);
    run_out(2, 20, "t6_count");
    chk("t6_w0", out_q[0], p3);
    chk("t6_w1", out_q[1], lzz);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
